assoc_cache_control: RTL and testbench
======================================

ASSOC_CACHE_CONTROL -- requirements
Module: assoc_cache_control

Interface
REQ-001 Parameter NUM_WAYS, default 4, ways per set; legal values 2, 4, 8.
REQ-002 Parameter SET_BITS, default 3, set-index width; 2**SET_BITS sets.
REQ-003 Derived WAY_BITS = log2(NUM_WAYS); not overridable.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 mem_read / mem_write  in  1 each  CPU request, held until mem_resp; never both high.
REQ-007 set_index  in  SET_BITS  set addressed by current CPU request.
REQ-008 hit_vec  in  NUM_WAYS  per-way tag match AND valid; at most one bit high.
REQ-009 valid_vec / dirty_vec  in  NUM_WAYS each  valid/dirty bits of addressed set.
REQ-010 pmem_resp  in  1  physical-memory completion pulse.
REQ-011 mem_resp  out  1  CPU request complete, one-cycle pulse.
REQ-012 pmem_read / pmem_write  out  1 each  physical-memory request, held until pmem_resp.
REQ-013 way_sel  out  WAY_BITS  way driven to data/tag muxes this cycle.
REQ-014 data_we / tag_we / valid_we / dirty_we  out  NUM_WAYS each  one-hot per-way array write enables.
REQ-015 dirty_in  out  1  value written on dirty_we.
REQ-016 datain_sel  out  1  0 = line from pmem, 1 = CPU write data merged.
REQ-017 addr_sel  out  1  pmem address: 0 = CPU tag, 1 = victim's stored tag.

Function
REQ-018 States SHALL be IDLE, EVICT, FILL; nothing else encoded.
REQ-019 IDLE, request, hit_vec != 0: mem_resp=1 same cycle, way_sel = hit way, PLRU of set_index updated to mark hit way most recent at clock edge.
REQ-020 Write hit SHALL additionally assert datain_sel=1, data_we and dirty_we of hit way, dirty_in=1.
REQ-021 IDLE, request, hit_vec == 0: victim computed; next state EVICT if victim valid and dirty, else FILL; victim registered at that edge and held until return to IDLE.
REQ-022 Victim SHALL be lowest-index way with valid_vec bit 0; if all valid, way selected by tree pseudo-LRU of set_index.
REQ-023 PLRU storage: 2**SET_BITS entries of NUM_WAYS-1 bits, tree-encoded; reads combinational, writes only on hit (REQ-019).
REQ-024 EVICT: pmem_write=1, addr_sel=1, way_sel=victim; on pmem_resp -> FILL (no IDLE detour).
REQ-025 FILL: pmem_read=1, addr_sel=0, way_sel=victim; on pmem_resp cycle assert data_we, tag_we, valid_we, dirty_we of victim, dirty_in=0, datain_sel=0; -> IDLE.
REQ-026 After FILL, the request SHALL complete as a hit in IDLE (minimum miss latency: clean 2 cycles + pmem wait, dirty 3 cycles + both waits).
REQ-027 All write enables SHALL be zero in every state/cycle not listed above; all outputs 0 in IDLE with no request.
REQ-028 pmem_resp outside EVICT/FILL SHALL be ignored.
REQ-029 mem_read and mem_write both high SHALL be treated as mem_read.

Reset
REQ-030 rst_n low SHALL force state IDLE, all PLRU entries 0, registered victim 0, all outputs 0, immediately, regardless of clock.
REQ-031 Reset mid-EVICT or mid-FILL SHALL abandon the transfer; pmem_read/pmem_write drop asynchronously; no array write occurs.
REQ-032 First clock edge after rst_n rises SHALL evaluate IDLE normally.

Verification
REQ-033 NUM_WAYS=4, read, hit_vec=0100 -> mem_resp=1 same cycle, way_sel=2, no write enables.
REQ-034 Write hit, hit_vec=0001 -> data_we=0001, dirty_we=0001, dirty_in=1, datain_sel=1, mem_resp=1.
REQ-035 Read miss, valid_vec=1011 -> FILL, way_sel=2; pmem_resp after 5 cycles -> valid_we=0100, then IDLE.
REQ-036 All valid, PLRU set 0 = 000, dirty_vec=1111, miss -> EVICT way 0 with addr_sel=1, pmem_resp -> FILL, pmem_resp -> IDLE.
REQ-037 Hits to ways 0,1,2 in set 5 then full-set miss -> victim way 3; set 4 PLRU unchanged.
REQ-038 rst_n low during FILL -> pmem_read=0 before next edge, state IDLE, no valid_we pulse.

Source files
------------

// File: rtl/assoc_cache_control.sv
// assoc_cache_control
//   Controller for an N-way set-associative cache. A hit completes in the
//   same cycle. A miss picks a victim way: the lowest invalid way, or the
//   way chosen by a per-set tree pseudo-LRU when every way is valid. A dirty
//   victim is written back (EVICT) before the line is refilled (FILL).
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   mem_read_i / mem_write_i    CPU request, held until mem_resp_o
//   set_index_i                 set addressed by the request
//   hit_vec_i                   per-way hit (tag match & valid), one-hot or 0
//   valid_vec_i / dirty_vec_i   valid/dirty bits of the addressed set
//   pmem_resp_i                 physical memory completion pulse
//   mem_resp_o                  CPU request complete (1-cycle pulse)
//   pmem_read_o / pmem_write_o  physical memory request, held until pmem_resp_i
//   way_sel_o                   way presented to the data/tag muxes
//   data_we_o, tag_we_o,
//   valid_we_o, dirty_we_o      one-hot per-way array write enables
//   dirty_in_o                  value written on dirty_we_o
//   datain_sel_o                0 = line from pmem, 1 = CPU write data merged
//   addr_sel_o                  pmem address: 0 = CPU tag, 1 = victim tag
module assoc_cache_control #(
  parameter int NUM_WAYS = 4,
  parameter int SET_BITS = 3,
  localparam int WAY_BITS = $clog2(NUM_WAYS),
  localparam int NUM_SETS = 1 << SET_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [SET_BITS-1:0] set_index_i,
  input  logic [NUM_WAYS-1:0] hit_vec_i,
  input  logic [NUM_WAYS-1:0] valid_vec_i,
  input  logic [NUM_WAYS-1:0] dirty_vec_i,
  input  logic                pmem_resp_i,
  output logic                mem_resp_o,
  output logic                pmem_read_o,
  output logic                pmem_write_o,
  output logic [WAY_BITS-1:0] way_sel_o,
  output logic [NUM_WAYS-1:0] data_we_o,
  output logic [NUM_WAYS-1:0] tag_we_o,
  output logic [NUM_WAYS-1:0] valid_we_o,
  output logic [NUM_WAYS-1:0] dirty_we_o,
  output logic                dirty_in_o,
  output logic                datain_sel_o,
  output logic                addr_sel_o
);

  typedef enum logic [1:0] {IDLE, EVICT, FILL} state_e;

  state_e              state_q, state_d;
  logic [WAY_BITS-1:0] victim_q, victim_d;

  // Tree PLRU, heap-numbered nodes 1..NUM_WAYS-1. Level l of the tree
  // decides bit l of the way index (LSB at the root); a node bit of 1 means
  // the least-recent side is the "1" subtree.
  logic [NUM_WAYS-1:1] plru_q [NUM_SETS];
  logic [NUM_WAYS-1:1] plru_cur, plru_upd;
  logic                plru_we;

  logic                req, is_wr, hit;
  logic [WAY_BITS-1:0] hit_way, plru_way, miss_way;
  logic [NUM_WAYS-1:0] vic_oh;

  // Read wins when both request lines are high.
  assign req    = mem_read_i | mem_write_i;
  assign is_wr  = mem_write_i & ~mem_read_i;
  assign hit    = |hit_vec_i;
  assign vic_oh = NUM_WAYS'(1) << victim_q;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (hit_vec_i[w]) hit_way = hit_way | WAY_BITS'(w);
  end

  // Walk the tree to the PLRU way, and build the entry that marks the hit
  // way most recent (each node on its path points away from it).
  always_comb begin
    logic [WAY_BITS-1:0] node;
    plru_cur = plru_q[set_index_i];
    plru_upd = plru_cur;
    plru_way = '0;
    node     = WAY_BITS'(1);
    for (int l = 0; l < WAY_BITS; l++) begin
      plru_way[l] = plru_cur[node];
      node        = WAY_BITS'({node, plru_cur[node]});
    end
    node = WAY_BITS'(1);
    for (int l = 0; l < WAY_BITS; l++) begin
      plru_upd[node] = ~hit_way[l];
      node           = WAY_BITS'({node, hit_way[l]});
    end
  end

  // Victim: lowest invalid way, else the PLRU way.
  always_comb begin
    logic found;
    found    = 1'b0;
    miss_way = plru_way;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!valid_vec_i[w] && !found) begin
        miss_way = WAY_BITS'(w);
        found    = 1'b1;
      end
  end

  // Next state and outputs. Outputs are combinational so a hit completes in
  // the cycle it is presented; they are forced low while reset is asserted.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    plru_we      = 1'b0;
    mem_resp_o   = 1'b0;
    pmem_read_o  = 1'b0;
    pmem_write_o = 1'b0;
    way_sel_o    = '0;
    data_we_o    = '0;
    tag_we_o     = '0;
    valid_we_o   = '0;
    dirty_we_o   = '0;
    dirty_in_o   = 1'b0;
    datain_sel_o = 1'b0;
    addr_sel_o   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req && hit) begin
            mem_resp_o = 1'b1;
            way_sel_o  = hit_way;
            plru_we    = 1'b1;
            if (is_wr) begin
              datain_sel_o = 1'b1;
              data_we_o    = hit_vec_i;
              dirty_we_o   = hit_vec_i;
              dirty_in_o   = 1'b1;
            end
          end else if (req) begin
            victim_d = miss_way;
            state_d  = (valid_vec_i[miss_way] && dirty_vec_i[miss_way]) ? EVICT : FILL;
          end
        end
        EVICT: begin
          pmem_write_o = 1'b1;
          addr_sel_o   = 1'b1;
          way_sel_o    = victim_q;
          if (pmem_resp_i) state_d = FILL;
        end
        FILL: begin
          pmem_read_o = 1'b1;
          way_sel_o   = victim_q;
          if (pmem_resp_i) begin
            data_we_o  = vic_oh;
            tag_we_o   = vic_oh;
            valid_we_o = vic_oh;
            dirty_we_o = vic_oh;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (plru_we) plru_q[set_index_i] <= plru_upd;
    end
  end

endmodule

// File: tb/tb_assoc_cache_control.sv
module tb_assoc_cache_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write, pmem_resp;
  logic [2:0] set_index;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic       mem_resp, pmem_read, pmem_write, dirty_in, datain_sel, addr_sel;
  logic [1:0] way_sel;
  logic [3:0] data_we, tag_we, valid_we, dirty_we;
  logic [31:0] all_o, we;
  int checks = 0;
  int errors = 0;

  assoc_cache_control #(.NUM_WAYS(4), .SET_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .set_index_i(set_index),
    .hit_vec_i(hit_vec), .valid_vec_i(valid_vec), .dirty_vec_i(dirty_vec),
    .pmem_resp_i(pmem_resp),
    .mem_resp_o(mem_resp), .pmem_read_o(pmem_read), .pmem_write_o(pmem_write),
    .way_sel_o(way_sel), .data_we_o(data_we), .tag_we_o(tag_we),
    .valid_we_o(valid_we), .dirty_we_o(dirty_we), .dirty_in_o(dirty_in),
    .datain_sel_o(datain_sel), .addr_sel_o(addr_sel)
  );

  always #5 clk = ~clk;

  assign we    = {16'b0, data_we, tag_we, valid_we, dirty_we};
  assign all_o = {8'b0, mem_resp, pmem_read, pmem_write, way_sel,
                  data_we, tag_we, valid_we, dirty_we, dirty_in, datain_sel, addr_sel};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] s,
                       input logic [3:0] h, input logic [3:0] v, input logic [3:0] d);
    mem_read = rd; mem_write = wr; set_index = s;
    hit_vec = h; valid_vec = v; dirty_vec = d;
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; pmem_resp = 1'b0;
    drive(1, 0, 1, 4'b0100, 4'b1111, 4'b0000);
    #3;
    chk("rst_outs_zero", all_o, 0);
    tick;
    rst_n = 1'b1;
    drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    #1 chk("idle_noreq", all_o, 0);

    // read hit way 2
    drive(1, 0, 1, 4'b0100, 4'b1111, 4'b0000);
    #1 chk("rd_hit_resp", mem_resp, 1);
    chk("rd_hit_way", way_sel, 2);
    chk("rd_hit_we", we, 0);

    // write hit way 0
    tick; drive(0, 1, 2, 4'b0001, 4'b1111, 4'b0000);
    #1 chk("wr_hit_resp", mem_resp, 1);
    chk("wr_hit_data_we", data_we, 4'b0001);
    chk("wr_hit_dirty_we", dirty_we, 4'b0001);
    chk("wr_hit_dirty_in", dirty_in, 1);
    chk("wr_hit_dsel", datain_sel, 1);
    chk("wr_hit_tag_valid_we", {tag_we, valid_we}, 0);

    // both high behaves as a read
    tick; drive(1, 1, 2, 4'b0001, 4'b1111, 4'b0000);
    #1 chk("both_resp", mem_resp, 1);
    chk("both_no_we", we, 0);

    // clean read miss, first invalid way is 2
    tick; drive(1, 0, 3, 4'b0000, 4'b1011, 4'b0000);
    #1 chk("miss_no_resp", {mem_resp, pmem_read, pmem_write}, 0);
    tick;
    chk("fill_pread", pmem_read, 1);
    chk("fill_way", way_sel, 2);
    chk("fill_addr_sel", addr_sel, 0);
    chk("fill_we_idle", we, 0);
    repeat (4) tick;
    chk("fill_wait_pread", pmem_read, 1);
    chk("fill_wait_we", we, 0);
    pmem_resp = 1'b1;
    #1 chk("fill_valid_we", valid_we, 4'b0100);
    chk("fill_all_we", we, 32'h4444);
    chk("fill_dirty_in_dsel", {dirty_in, datain_sel, mem_resp}, 0);
    tick; pmem_resp = 1'b0;
    drive(1, 0, 3, 4'b0100, 4'b1111, 4'b0000);
    #1 chk("after_fill_hit", {mem_resp, way_sel}, {1'b1, 2'd2});

    // dirty full-set miss in set 0 (PLRU 000 -> way 0)
    tick; drive(1, 0, 0, 4'b0000, 4'b1111, 4'b1111);
    tick;
    chk("evict_pwrite", pmem_write, 1);
    chk("evict_addr_sel", addr_sel, 1);
    chk("evict_way", way_sel, 0);
    chk("evict_pread", pmem_read, 0);
    pmem_resp = 1'b1;
    #1 chk("evict_resp_no_we", we, 0);
    tick; pmem_resp = 1'b0;
    #1 chk("e2f_state", {pmem_read, pmem_write, addr_sel, way_sel}, {1'b1, 1'b0, 1'b0, 2'd0});
    pmem_resp = 1'b1;
    #1 chk("e2f_valid_we", valid_we, 4'b0001);
    tick; pmem_resp = 1'b0;
    drive(1, 0, 0, 4'b0001, 4'b1111, 4'b0000);
    #1 chk("e2f_done_hit", mem_resp, 1);

    // stray pmem_resp in IDLE ignored
    tick; drive(0, 0, 0, 4'b0000, 4'b1111, 4'b0000); pmem_resp = 1'b1;
    #1 chk("stray_resp_outs", all_o, 0);
    tick; pmem_resp = 1'b0;
    drive(1, 0, 0, 4'b0010, 4'b1111, 4'b0000);
    #1 chk("stray_still_idle", {mem_resp, way_sel}, {1'b1, 2'd1});

    // hits 0,1,2 in set 5, then full-set miss -> way 3
    for (int w = 0; w < 3; w++) begin
      tick; drive(1, 0, 5, 4'(1 << w), 4'b1111, 4'b0000);
      #1 chk("set5_hit", mem_resp, 1);
    end
    tick; drive(1, 0, 5, 4'b0000, 4'b1111, 4'b0000);
    tick;
    chk("set5_victim", {pmem_read, way_sel}, {1'b1, 2'd3});
    pmem_resp = 1'b1;
    #1 chk("set5_valid_we", valid_we, 4'b1000);
    tick; pmem_resp = 1'b0; drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    // set 4 untouched -> way 0
    tick; drive(1, 0, 4, 4'b0000, 4'b1111, 4'b0000);
    tick;
    chk("set4_victim", {pmem_read, pmem_write, way_sel}, {1'b1, 1'b0, 2'd0});
    pmem_resp = 1'b1;
    tick; pmem_resp = 1'b0; drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

    // reset during FILL
    tick; drive(1, 0, 6, 4'b0000, 4'b0000, 4'b0000);
    tick;
    chk("pre_rst_fill", pmem_read, 1);
    rst_n = 1'b0; pmem_resp = 1'b1;
    #1 chk("rst_fill_pread", pmem_read, 0);
    chk("rst_fill_no_we", we, 0);
    chk("rst_fill_outs", all_o, 0);
    tick;
    rst_n = 1'b1; pmem_resp = 1'b0;
    drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    #1 chk("post_rst_idle", all_o, 0);
    drive(1, 0, 6, 4'b0001, 4'b1111, 4'b0000);
    #1 chk("post_rst_hit", mem_resp, 1);
    // set 5 PLRU cleared by reset -> victim 0 again
    tick; drive(1, 0, 5, 4'b0000, 4'b1111, 4'b0000);
    tick;
    chk("post_rst_set5_victim", {pmem_read, way_sel}, {1'b1, 2'd0});
    pmem_resp = 1'b1;
    tick; pmem_resp = 1'b0; drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    #1 chk("final_idle", all_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
